// File: rtl/wb_stage_n_pkg.sv
// Shared definitions for the writeback stage.
// - Scoreboard id width default (low index bits plus one wrap bit).
// - FSM state encodings for the redirect tracker.
// - sid_older(): age compare of two wrap-tagged scoreboard ids.
package wb_stage_n_pkg;

    localparam int unsigned ScoreboardSizeWidth = 3;
    localparam int unsigned SidWDefault         = ScoreboardSizeWidth + 1;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StPend = 1'b1;

    // a is older than b. Ids are zero-extended to 32 bits; w is the real id width.
    // With equal wrap bits the smaller index is older; across a wrap the
    // comparison inverts.
    function automatic logic sid_older(input logic [31:0] a, input logic [31:0] b,
                                       input int unsigned w);
        logic [31:0] msb_mask;
        logic [31:0] low_mask;
        logic        a_msb;
        logic        b_msb;
        msb_mask = 32'd1 << (w - 32'd1);
        low_mask = msb_mask - 32'd1;
        a_msb    = |(a & msb_mask);
        b_msb    = |(b & msb_mask);
        if (a_msb == b_msb) begin
            return (a & low_mask) < (b & low_mask);
        end
        return (a & low_mask) > (b & low_mask);
    endfunction

endpackage

// File: rtl/wb_lane_reg.sv
// Single writeback lane register.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_*_i                incoming result payload for this lane
//   stall_i / flush_i     hold request / kill (flush_i already includes global kill)
//   capture_i             this lane's redirect was taken by the redirect tracker
//   valid_o, redirect_o   registered lane state
//   rd_o .. sid_o         registered payload (not reset)
module wb_lane_reg #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned SID_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    input  logic             in_redirect_i,
    input  logic [4:0]       in_rd_i,
    input  logic [XLEN-1:0]  in_value_i,
    input  logic [XLEN-1:0]  in_redirect_pc_i,
    input  logic [SID_W-1:0] in_sid_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             capture_i,
    output logic             valid_o,
    output logic             redirect_o,
    output logic [4:0]       rd_o,
    output logic [XLEN-1:0]  value_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic [SID_W-1:0] sid_o
);

    logic valid_d, valid_q;
    logic redirect_d, redirect_q;
    logic load;

    always_comb begin
        valid_d    = 1'b0;
        redirect_d = 1'b0;
        load       = 1'b0;
        if (flush_i) begin
            valid_d    = 1'b0;
            redirect_d = 1'b0;
        end else if (in_valid_i) begin
            valid_d    = 1'b1;
            redirect_d = in_redirect_i;
            load       = 1'b1;
        end else if (stall_i) begin
            valid_d    = valid_q;
            // A held redirect must not be offered again once taken.
            redirect_d = redirect_q & ~capture_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            redirect_q <= redirect_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            rd_o          <= in_rd_i;
            value_o       <= in_value_i;
            redirect_pc_o <= in_redirect_pc_i;
            sid_o         <= in_sid_i;
        end
    end

    assign valid_o    = valid_q;
    assign redirect_o = redirect_q;

endmodule

// File: rtl/wb_stage_n.sv
// Multi-lane writeback stage with redirect arbitration.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid_i/in_redirect_i   per-lane result present / result wants a redirect
//   in_rd_i, in_value_i,
//   in_redirect_pc_i, in_sid_i per-lane payload (packed, lane k at slice k)
//   stall_i, flush_i           per-lane hold / kill
//   flush_all_i                kill every lane and any pending redirect
//   wb_*_o                     registered writeback towards regfile/scoreboard
//   redirect_*_o               redirect request towards the frontend
//   redirect_ready_i           frontend accepts the redirect
module wb_stage_n
    import wb_stage_n_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned XLEN  = 64,
    parameter int unsigned SID_W = SidWDefault
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES-1:0]       in_valid_i,
    input  logic [LANES-1:0]       in_redirect_i,
    input  logic [LANES*5-1:0]     in_rd_i,
    input  logic [LANES*XLEN-1:0]  in_value_i,
    input  logic [LANES*XLEN-1:0]  in_redirect_pc_i,
    input  logic [LANES*SID_W-1:0] in_sid_i,
    input  logic [LANES-1:0]       stall_i,
    input  logic [LANES-1:0]       flush_i,
    input  logic                   flush_all_i,
    output logic [LANES-1:0]       wb_valid_o,
    output logic [LANES*5-1:0]     wb_rd_o,
    output logic [LANES*XLEN-1:0]  wb_value_o,
    output logic [LANES*SID_W-1:0] wb_sid_o,
    output logic                   redirect_valid_o,
    output logic [XLEN-1:0]        redirect_pc_o,
    output logic [SID_W-1:0]       redirect_sid_o,
    input  logic                   redirect_ready_i
);

    logic [LANES-1:0] valid_r, redirect_r;
    logic [SID_W-1:0] sid_r [LANES];
    logic [XLEN-1:0]  pc_r  [LANES];

    logic [LANES-1:0] flushed, pend_squash, cand_squash, eligible, cand_sel;
    logic             cand_found;
    logic [SID_W-1:0] cand_sid;
    logic [XLEN-1:0]  cand_pc;

    logic [0:0]       state_d, state_q;
    logic [XLEN-1:0]  redir_pc_d, redir_pc_q;
    logic [SID_W-1:0] redir_sid_d, redir_sid_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        wb_lane_reg #(
            .XLEN (XLEN),
            .SID_W(SID_W)
        ) u_lane (
            .clk             (clk),
            .rst_n           (rst_n),
            .in_valid_i      (in_valid_i[k]),
            .in_redirect_i   (in_redirect_i[k]),
            .in_rd_i         (in_rd_i[k*5 +: 5]),
            .in_value_i      (in_value_i[k*XLEN +: XLEN]),
            .in_redirect_pc_i(in_redirect_pc_i[k*XLEN +: XLEN]),
            .in_sid_i        (in_sid_i[k*SID_W +: SID_W]),
            .stall_i         (stall_i[k]),
            .flush_i         (flushed[k]),
            .capture_i       (cand_sel[k]),
            .valid_o         (valid_r[k]),
            .redirect_o      (redirect_r[k]),
            .rd_o            (wb_rd_o[k*5 +: 5]),
            .value_o         (wb_value_o[k*XLEN +: XLEN]),
            .redirect_pc_o   (pc_r[k]),
            .sid_o           (sid_r[k])
        );
        assign wb_sid_o[k*SID_W +: SID_W] = sid_r[k];
    end

    // Candidate selection and wrong-path squash.
    always_comb begin
        flushed     = flush_i | {LANES{flush_all_i}};
        pend_squash = '0;
        cand_squash = '0;
        cand_found  = 1'b0;
        cand_sid    = '0;
        cand_pc     = '0;
        cand_sel    = '0;
        for (int k = 0; k < LANES; k++) begin
            pend_squash[k] = (state_q == StPend) &&
                             sid_older(32'(redir_sid_q), 32'(sid_r[k]), SID_W);
        end
        eligible = valid_r & redirect_r & ~flushed & ~pend_squash;
        for (int k = 0; k < LANES; k++) begin
            if (eligible[k] &&
                (!cand_found || sid_older(32'(sid_r[k]), 32'(cand_sid), SID_W))) begin
                cand_found  = 1'b1;
                cand_sid    = sid_r[k];
                cand_pc     = pc_r[k];
                cand_sel    = '0;
                cand_sel[k] = 1'b1;
            end
        end
        // The candidate never squashes itself: its own sid is not younger.
        for (int k = 0; k < LANES; k++) begin
            cand_squash[k] = cand_found &&
                             sid_older(32'(cand_sid), 32'(sid_r[k]), SID_W);
        end
        wb_valid_o = valid_r & ~flushed & ~pend_squash & ~cand_squash;
    end

    // Redirect tracker. Any candidate is older than a held redirect (younger
    // ones are squashed above), so a candidate always replaces the held one.
    always_comb begin
        state_d     = state_q;
        redir_pc_d  = redir_pc_q;
        redir_sid_d = redir_sid_q;
        if (flush_all_i) begin
            state_d = StIdle;
        end else if (cand_found) begin
            state_d     = StPend;
            redir_pc_d  = cand_pc;
            redir_sid_d = cand_sid;
        end else if ((state_q == StPend) && redirect_ready_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            redir_pc_q  <= '0;
            redir_sid_q <= '0;
        end else begin
            state_q     <= state_d;
            redir_pc_q  <= redir_pc_d;
            redir_sid_q <= redir_sid_d;
        end
    end

    assign redirect_valid_o = (state_q == StPend);
    assign redirect_pc_o    = redir_pc_q;
    assign redirect_sid_o   = redir_sid_q;

endmodule

// File: doc/wb_stage_n.md
WB_STAGE_N -- requirements
Module: wb_stage_n

Interface
REQ-001 Parameter LANES, default 2, number of writeback lanes (1..4); lane 0 is program-order oldest within a cycle.
REQ-002 Parameter XLEN, default 64, result and PC width.
REQ-003 Parameter SID_W, default `SCOREBOARD_SIZE_WIDTH+1, scoreboard id width; MSB is the wrap bit.
REQ-004 clk  in  1  sole clock; one clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid_i / in_redirect_i  in  LANES  per-lane result present / result requests redirect.
REQ-007 in_rd_i  in  LANES*5; in_value_i, in_redirect_pc_i  in  LANES*XLEN; in_sid_i  in  LANES*SID_W; per-lane payload.
REQ-008 stall_i / flush_i  in  LANES  per-lane hold request / per-lane kill.
REQ-009 flush_all_i  in  1  global kill of lanes and pending redirect.
REQ-010 wb_valid_o  out  LANES; wb_rd_o  out  LANES*5; wb_value_o  out  LANES*XLEN; wb_sid_o  out  LANES*SID_W; registered writeback to regfile/scoreboard.
REQ-011 redirect_valid_o  out  1; redirect_pc_o  out  XLEN; redirect_sid_o  out  SID_W; redirect request to frontend.
REQ-012 redirect_ready_i  in  1  frontend accepts redirect when high with redirect_valid_o.

Function
REQ-013 Age order SHALL be: a older than b iff (a.msb==b.msb ? a.low<b.low : a.low>b.low); equal sids are never compared across live entries.
REQ-014 Per lane, priority each cycle: flush_i[k] or flush_all_i clears valid; else in_valid_i[k] loads payload and sets valid; else stall_i[k] holds; else valid clears.
REQ-015 Payload registers SHALL load only when loaded per REQ-014; latency input to wb_*_o is one cycle.
REQ-016 wb_valid_o[k] = valid_r[k] & ~flush_i[k] & ~flush_all_i & ~squash[k].
REQ-017 squash[k] SHALL be high when lane k sid is younger than the pending redirect sid (state PEND) or younger than the candidate selected this cycle.
REQ-018 Candidate: among lanes with valid_r, redirect_r, not flushed, not squashed by PEND sid, the oldest by REQ-013; ties impossible.
REQ-019 FSM states IDLE, PEND; redirect_valid_o = (state==PEND).
REQ-020 IDLE: candidate exists -> capture pc/sid, go PEND next cycle (redirect visible two cycles after input).
REQ-021 PEND: redirect_ready_i -> IDLE, unless a candidate exists that cycle, then capture it and stay PEND.
REQ-022 PEND without ready: candidate older than held sid replaces pc/sid; younger candidates are ignored; redirect_pc_o/sid_o stable otherwise.
REQ-023 flush_all_i SHALL force IDLE next cycle regardless of ready or candidates.
REQ-024 The redirecting instruction itself SHALL still write back (not squashed by its own sid).
REQ-025 Stalled lane holding a redirect SHALL not re-raise a candidate after its redirect was captured (per-lane redirect_r cleared on capture).

Reset
REQ-026 rst_n low at a clock edge: all valid_r, redirect_r clear, state IDLE; wb_valid_o=0, redirect_valid_o=0, redirect_pc_o=0, redirect_sid_o=0 from that edge.
REQ-027 Payload registers need no reset; reset mid-PEND drops the redirect without a handshake.

Structure
REQ-028 Shared package holds sid_older function, SID_W default, and FSM state encoding constants.
REQ-029 One sub-module wb_lane_reg (single lane register, REQ-014/015) instantiated LANES times via generate.

Verification
REQ-030 Lane0 valid rd=5 value=0x1234 sid=3, no stall -> cycle+1 wb_valid_o[0]=1 rd=5 value=0x1234; cycle+2 wb_valid_o[0]=0.
REQ-031 Lane1 redirect pc=0x8000_0100 sid=6, ready=1 -> redirect_valid_o one cycle at t+2 with pc 0x8000_0100 sid 6; lane1 still writes back.
REQ-032 Lanes 0/1 both redirect, sids 0b1_001 and 0b0_111 (wrap) -> sid 0b0_111 selected, lane with 0b1_001 wb_valid_o=0.
REQ-033 PEND sid=4, ready=0 for 3 cycles, new candidate sid=2 -> pc/sid replaced by sid 2; candidate sid=9 ignored and squashed.
REQ-034 stall_i[0]=1 with valid entry for 4 cycles -> wb_valid_o[0] held 4 cycles, value unchanged; flush_i[0] mid-stall -> wb_valid_o[0]=0 same cycle.
REQ-035 flush_all_i in PEND, and rst_n=0 in PEND -> redirect_valid_o=0 next cycle, all wb_valid_o=0.
